mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide unit.
// MULT uses radix-2 Booth and DIV uses restoring division on magnitudes.
// Each runs 32 iterations, one per clock, and loads HI/LO on entry to DONE.
// Optional macro MULTDIV_DIVZERO_EXC_EN: a divide by zero skips the iterations
// and raises div_zero together with mult_end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             mult_control,
  input  logic             DivOp,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_end,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // acc has one guard bit above WIDTH. Without it, Booth's subtraction of the
  // most negative multiplicand overflows, as in 0x80000000 * 0x80000000.
  // DIV also uses acc as the partial remainder.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg;   // multiplier (MULT) or dividend/quotient (DIV)
  logic [WIDTH-1:0] breg;   // multiplicand (MULT) or |divisor| (DIV)
  logic             qm1;
  logic             a_neg;
  logic             b_neg;

  logic             last_iter;
  logic             div_skip;

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc_n;
  logic [WIDTH-1:0] booth_q_n;
  logic             booth_qm1_n;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_neg;
  logic [WIDTH:0]   div_rem_n;
  logic [WIDTH-1:0] div_quot_n;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] div_hi;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MULTDIV_DIVZERO_EXC_EN
  assign div_skip = (breg == '0);
`else
  assign div_skip = 1'b0;
`endif

  // Operand magnitudes for DIV, taken from the inputs at the start edge
  always_comb begin
    a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    b_mag = op_b[WIDTH-1] ? -op_b : op_b;
  end

  // One Booth step: add/subtract on the {q0, q-1} pair, then arithmetic shift right
  always_comb begin
    mcand_ext = {breg[WIDTH-1], breg};
    case ({qreg[0], qm1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    booth_acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q_n   = {booth_sum[0], qreg[WIDTH-1:1]};
    booth_qm1_n = qreg[0];
  end

  // One restoring-division step plus the sign fix-up of the final result
  always_comb begin
    div_shift  = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, breg};
    div_neg    = div_diff[WIDTH+1];
    div_rem_n  = div_neg ? div_shift : div_diff[WIDTH:0];
    div_quot_n = {qreg[WIDTH-2:0], ~div_neg};
    div_lo     = (a_neg ^ b_neg) ? -div_quot_n : div_quot_n;
    div_hi     = a_neg ? -div_rem_n[WIDTH-1:0] : div_rem_n[WIDTH-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  // A start is also accepted in DONE, so operations can run back to back every 33 cycles.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      qreg     <= '0;
      breg     <= '0;
      qm1      <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      mult_end <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      mult_end <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (mult_control) begin
            acc   <= '0;
            qreg  <= op_b;
            breg  <= op_a;
            qm1   <= 1'b0;
            cnt   <= '0;
            state <= S_MULT;
            busy  <= 1'b1;
          end else if (DivOp) begin
            acc   <= '0;
            qreg  <= a_mag;
            breg  <= b_mag;
            qm1   <= 1'b0;
            a_neg <= op_a[WIDTH-1];
            b_neg <= op_b[WIDTH-1];
            cnt   <= '0;
            state <= S_DIV;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_MULT: begin
          acc  <= booth_acc_n;
          qreg <= booth_q_n;
          qm1  <= booth_qm1_n;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            HI       <= booth_acc_n[WIDTH-1:0];
            LO       <= booth_q_n;
            mult_end <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          if (div_skip) begin
            mult_end <= 1'b1;
            div_zero <= 1'b1;
            state    <= S_DONE;
          end else begin
            acc  <= div_rem_n;
            qreg <= div_quot_n;
            cnt  <= cnt + CW'(1);
            if (last_iter) begin
              HI       <= div_hi;
              LO       <= div_lo;
              mult_end <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed, self-checking bench for mult_div_unit.
// Inputs are driven 1 ns after a rising edge and outputs are sampled there too.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        mult_control = 1'b0;
  logic        DivOp = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        mult_end;
  logic        busy;
  logic        div_zero;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .mult_control (mult_control),
    .DivOp        (DivOp),
    .op_a         (op_a),
    .op_b         (op_b),
    .HI           (HI),
    .LO           (LO),
    .mult_end     (mult_end),
    .busy         (busy),
    .div_zero     (div_zero)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge (E0); leaves time at E0+1ns
  task automatic start_op(input logic mc, input logic dv, input logic [31:0] a, input logic [31:0] b);
    mult_control = mc;
    DivOp        = dv;
    op_a         = a;
    op_b         = b;
    step();
    mult_control = 1'b0;
    DivOp        = 1'b0;
  endtask

  // Count edges until mult_end is seen (bounded); also reports whether busy ever dropped
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      step();
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (mult_end === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    step();
    step();
    reset_in = 1'b0;
    total++;
    if ({HI, LO} !== 64'h0) begin
      bad++;
      $display("FAIL reset_hilo: got %h want %h", {HI, LO}, 64'h0);
    end
    total++;
    if ({mult_end, busy, div_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want %b", {mult_end, busy, div_zero}, 3'b000);
    end
  endtask

  task automatic test_mult_basic();
    int n;
    logic bok;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    total++;
    if ({busy, mult_end} !== 2'b10) begin
      bad++;
      $display("FAIL mult_e0_flags: got %b want %b", {busy, mult_end}, 2'b10);
    end
    wait_done(n, bok);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL mult_latency: got %0d want %0d", n, 32);
    end
    total++;
    if (bok !== 1'b1) begin
      bad++;
      $display("FAIL mult_busy_hold: got %b want %b", bok, 1'b1);
    end
    total++;
    if ({HI, LO} !== 64'h00000000_0000002A) begin
      bad++;
      $display("FAIL mult_6x7: got %h want %h", {HI, LO}, 64'h00000000_0000002A);
    end
    step();
    total++;
    if ({busy, mult_end} !== 2'b00) begin
      bad++;
      $display("FAIL mult_e33_flags: got %b want %b", {busy, mult_end}, 2'b00);
    end
    total++;
    if (LO !== 32'h0000002A) begin
      bad++;
      $display("FAIL mult_hold: got %h want %h", LO, 32'h0000002A);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic bok;
    start_op(1'b1, 1'b0, -32'sd3, 32'd5);
    wait_done(n, bok);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL b2b_first_latency: got %0d want %0d", n, 32);
    end
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFF1) begin
      bad++;
      $display("FAIL mult_neg3x5: got %h want %h", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
    end
    // second start sampled at E33 of the first operation
    start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    total++;
    if ({busy, mult_end} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_restart_flags: got %b want %b", {busy, mult_end}, 2'b10);
    end
    wait_done(n, bok);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL b2b_second_latency: got %0d want %0d", n, 32);
    end
    total++;
    if ({HI, LO} !== 64'h40000000_00000000) begin
      bad++;
      $display("FAIL mult_minsq: got %h want %h", {HI, LO}, 64'h40000000_00000000);
    end
    step();
  endtask

  task automatic test_div();
    int n;
    logic bok;
    start_op(1'b0, 1'b1, -32'sd7, 32'd2);
    wait_done(n, bok);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL div_latency: got %0d want %0d", n, 32);
    end
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) begin
      bad++;
      $display("FAIL div_neg7_2: got %h want %h", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    end
    step();
    start_op(1'b0, 1'b1, 32'd100, -32'sd7);
    wait_done(n, bok);
    total++;
    if ({HI, LO} !== 64'h00000002_FFFFFFF2) begin
      bad++;
      $display("FAIL div_100_neg7: got %h want %h", {HI, LO}, 64'h00000002_FFFFFFF2);
    end
    step();
    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, bok);
    total++;
    if ({HI, LO} !== 64'h00000000_80000000) begin
      bad++;
      $display("FAIL div_min_neg1: got %h want %h", {HI, LO}, 64'h00000000_80000000);
    end
    total++;
    if (div_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_min_neg1_flag: got %b want %b", div_zero, 1'b0);
    end
    step();
  endtask

  task automatic test_div_zero();
    int n;
    logic bok;
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done(n, bok);
`ifdef MULTDIV_DIVZERO_EXC_EN
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL divz_latency: got %0d want %0d", n, 1);
    end
    total++;
    if (div_zero !== 1'b1) begin
      bad++;
      $display("FAIL divz_flag: got %b want %b", div_zero, 1'b1);
    end
    total++;
    if ({HI, LO} !== 64'h00000000_80000000) begin
      bad++;
      $display("FAIL divz_hilo_hold: got %h want %h", {HI, LO}, 64'h00000000_80000000);
    end
    step();
    total++;
    if ({mult_end, div_zero, busy} !== 3'b000) begin
      bad++;
      $display("FAIL divz_after: got %b want %b", {mult_end, div_zero, busy}, 3'b000);
    end
`else
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL divz_latency: got %0d want %0d", n, 32);
    end
    total++;
    if (div_zero !== 1'b0) begin
      bad++;
      $display("FAIL divz_flag: got %b want %b", div_zero, 1'b0);
    end
    total++;
    if ({HI, LO} !== 64'h00000005_FFFFFFFF) begin
      bad++;
      $display("FAIL divz_result: got %h want %h", {HI, LO}, 64'h00000005_FFFFFFFF);
    end
    step();
`endif
  endtask

  task automatic test_both_start();
    int n;
    logic bok;
    logic extra;
    start_op(1'b1, 1'b1, 32'd4, 32'd2);
    for (int i = 1; i < 10; i++) step();
    // DivOp sampled at E10 while busy must be ignored
    start_op(1'b0, 1'b1, 32'd100, 32'd3);
    wait_done(n, bok);
    total++;
    if (n !== 22) begin
      bad++;
      $display("FAIL both_latency: got %0d want %0d", n, 22);
    end
    total++;
    if ({HI, LO} !== 64'h00000000_00000008) begin
      bad++;
      $display("FAIL both_mult_wins: got %h want %h", {HI, LO}, 64'h00000000_00000008);
    end
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mult_end !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++;
      $display("FAIL both_no_extra_op: got %b want %b", extra, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic bok;
    logic seen;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    for (int i = 1; i < 15; i++) step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    total++;
    if ({HI, LO} !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_hilo: got %h want %h", {HI, LO}, 64'h0);
    end
    total++;
    if ({busy, mult_end} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_flags: got %b want %b", {busy, mult_end}, 2'b00);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mult_end !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_end: got %b want %b", seen, 1'b0);
    end
    start_op(1'b1, 1'b0, 32'd9, -32'sd2);
    wait_done(n, bok);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL rstmid_restart_latency: got %0d want %0d", n, 32);
    end
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFEE) begin
      bad++;
      $display("FAIL rstmid_restart: got %h want %h", {HI, LO}, 64'hFFFFFFFF_FFFFFFEE);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_mult_basic();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_both_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
